layer_norm_stream: RTL and testbench

- Streaming fixed-point LayerNorm with affine output, y = gamma*(x-mean)/std + beta.
- Accepts one token of EMBED_DIM elements serially over a valid/ready input.
- Computes mean and variance, integer sqrt and reciprocal with sequential units, then streams normalized elements out under backpressure.
- Sits between the attention/MLP blocks of the MobileViT transformer datapath; parametrised successor of the single-shot normalizer.

---
 rtl/layer_norm_stream.sv | 256 +++++++++++++++++++++++++
 tb/tb_layer_norm_stream.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_norm_stream.sv
// layer_norm_stream: streaming fixed-point LayerNorm, y = gamma*(x-mean)/std + beta, optional affine bypass.
// Latency: last input handshake to first out_valid is 2+DATA_WIDTH+2*FRAC_BITS cycles (34 at defaults).
// Backpressure: in_ready low from last input until the token drains; out_data/out_last hold while out_ready low.
module layer_norm_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int EMBED_DIM  = 8,
    parameter int EPS        = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         affine_bypass,
    input  logic signed [DATA_WIDTH-1:0] gamma_in [EMBED_DIM],
    input  logic signed [DATA_WIDTH-1:0] beta_in  [EMBED_DIM],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_last,
    output logic                         busy
);

    localparam int LOG2_N = $clog2(EMBED_DIM);
    localparam int CNT_W  = LOG2_N;
    localparam int SUM_W  = DATA_WIDTH + LOG2_N;
    localparam int SQ_W   = 2*DATA_WIDTH + LOG2_N;
    localparam int VAR_W  = 2*DATA_WIDTH;
    localparam int VR_W   = 2*SUM_W + 2;
    localparam int STD_W  = DATA_WIDTH;
    localparam int SREM_W = STD_W + 3;
    localparam int DREM_W = STD_W + 2;
    localparam int INV_W  = 2*FRAC_BITS + 1;
    localparam int STEP_W = $clog2(DATA_WIDTH + INV_W);
    localparam int DIFF_W = SUM_W + 1;
    localparam int P1_W   = DIFF_W + INV_W + 1;
    localparam int P2_W   = P1_W + DATA_WIDTH;
    localparam int Y_W    = P2_W + 1;

    localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(EMBED_DIM - 1);
    localparam logic [STEP_W-1:0] SQRT_LAST  = STEP_W'(DATA_WIDTH - 1);
    localparam logic [STEP_W-1:0] RECIP_LAST = STEP_W'(INV_W - 1);
    localparam logic signed [Y_W-1:0] Y_MAX = {{(Y_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [Y_W-1:0] Y_MIN = {{(Y_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_ACCUM,
        S_STATS,
        S_SQRT,
        S_RECIP,
        S_NORM
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [SUM_W-1:0]   sum_q, sum_d;
    logic [SQ_W-1:0]           sumsq_q, sumsq_d;
    logic signed [SUM_W-1:0]   mean_q, mean_d;
    logic                      bypass_q, bypass_d;
    logic [VAR_W-1:0]          rad_q, rad_d;
    logic [STD_W-1:0]          root_q, root_d;
    logic [SREM_W-1:0]         srem_q, srem_d;
    logic [DREM_W-1:0]         drem_q, drem_d;
    logic [INV_W-1:0]          quot_q, quot_d;
    logic [STEP_W-1:0]         step_q, step_d;
    logic signed [DATA_WIDTH-1:0] buf_q [EMBED_DIM];
    logic                      buf_we;

    // Statistics / iteration helpers
    logic signed [2*DATA_WIDTH-1:0] x_ext, x_sq;
    logic signed [SUM_W-1:0]   mean_c;
    logic signed [VR_W-1:0]    m_ext, mean_sq, sq_avg, var_raw, var_pos, var_eps;
    logic [VAR_W-1:0]          var_c;
    logic [SREM_W-1:0]         s_rem_sh, s_trial;
    logic                      s_ge;
    logic [STD_W-1:0]          std_c;
    logic [DREM_W-1:0]         d_rem_sh, d_std;
    logic                      d_ge;

    // Normalisation / affine helpers
    logic signed [DIFF_W-1:0]  diff;
    logic signed [INV_W:0]     inv_s;
    logic signed [P1_W-1:0]    p1, nrm;
    logic signed [P2_W-1:0]    p2;
    logic signed [Y_W-1:0]     aff, pick;
    logic signed [DATA_WIDTH-1:0] y_sat;

    // Mean/variance, one sqrt step and one divide step, evaluated from the current registers
    always_comb begin
        x_ext    = (2*DATA_WIDTH)'(in_data);
        x_sq     = x_ext * x_ext;
        mean_c   = sum_q >>> LOG2_N;
        m_ext    = VR_W'(mean_c);
        mean_sq  = m_ext * m_ext;
        sq_avg   = $signed(VR_W'(sumsq_q >> LOG2_N));
        var_raw  = sq_avg - mean_sq;
        var_pos  = var_raw[VR_W-1] ? '0 : var_raw;
        var_eps  = var_pos + VR_W'(EPS);
        var_c    = (|var_eps[VR_W-1:VAR_W]) ? '1 : VAR_W'(var_eps);

        s_rem_sh = SREM_W'({srem_q, rad_q[VAR_W-1 -: 2]});
        s_trial  = SREM_W'({root_q, 2'b01});
        s_ge     = (s_rem_sh >= s_trial);

        // Dividend is 2^(2*FRAC_BITS): only its MSB, fed on the first step, is set.
        std_c    = (root_q == '0) ? STD_W'(1) : root_q;
        d_rem_sh = DREM_W'({drem_q, (step_q == '0)});
        d_std    = DREM_W'(std_c);
        d_ge     = (d_rem_sh >= d_std);
    end

    // Output element: normalise, optional affine, then saturate; all intermediates full width
    always_comb begin
        diff  = DIFF_W'(buf_q[cnt_q]) - DIFF_W'(mean_q);
        inv_s = $signed({1'b0, quot_q});
        p1    = P1_W'(diff) * P1_W'(inv_s);
        nrm   = p1 >>> FRAC_BITS;
        p2    = P2_W'(nrm) * P2_W'(gamma_in[cnt_q]);
        aff   = Y_W'(p2 >>> FRAC_BITS) + Y_W'(beta_in[cnt_q]);
        pick  = bypass_q ? Y_W'(nrm) : aff;
        if (pick > Y_MAX) begin
            y_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (pick < Y_MIN) begin
            y_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            y_sat = DATA_WIDTH'(pick);
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        sumsq_d  = sumsq_q;
        mean_d   = mean_q;
        bypass_d = bypass_q;
        rad_d    = rad_q;
        root_d   = root_q;
        srem_d   = srem_q;
        drem_d   = drem_q;
        quot_d   = quot_q;
        step_d   = step_q;
        buf_we   = 1'b0;

        in_ready  = (state_q == S_ACCUM);
        out_valid = (state_q == S_NORM);
        out_last  = (state_q == S_NORM) && (cnt_q == LAST_IDX);
        out_data  = (state_q == S_NORM) ? y_sat : '0;
        busy      = !((state_q == S_ACCUM) && (cnt_q == '0));

        case (state_q)
            S_ACCUM: begin
                if (in_valid) begin
                    buf_we  = 1'b1;
                    sum_d   = sum_q + SUM_W'(in_data);
                    sumsq_d = sumsq_q + SQ_W'($unsigned(x_sq));
                    if (cnt_q == '0) begin
                        bypass_d = affine_bypass;
                    end
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = S_STATS;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_STATS: begin
                mean_d  = mean_c;
                rad_d   = var_c;
                root_d  = '0;
                srem_d  = '0;
                step_d  = '0;
                state_d = S_SQRT;
            end
            S_SQRT: begin
                rad_d  = rad_q << 2;
                root_d = {root_q[STD_W-2:0], s_ge};
                srem_d = s_ge ? (s_rem_sh - s_trial) : s_rem_sh;
                step_d = step_q + STEP_W'(1);
                if (step_q == SQRT_LAST) begin
                    step_d  = '0;
                    drem_d  = '0;
                    quot_d  = '0;
                    state_d = S_RECIP;
                end
            end
            S_RECIP: begin
                drem_d = d_ge ? (d_rem_sh - d_std) : d_rem_sh;
                quot_d = {quot_q[INV_W-2:0], d_ge};
                step_d = step_q + STEP_W'(1);
                if (step_q == RECIP_LAST) begin
                    step_d  = '0;
                    cnt_d   = '0;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        sum_d   = '0;
                        sumsq_d = '0;
                        state_d = S_ACCUM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_ACCUM;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial token
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_ACCUM;
            cnt_q    <= '0;
            sum_q    <= '0;
            sumsq_q  <= '0;
            mean_q   <= '0;
            bypass_q <= 1'b0;
            rad_q    <= '0;
            root_q   <= '0;
            srem_q   <= '0;
            drem_q   <= '0;
            quot_q   <= '0;
            step_q   <= '0;
            for (int i = 0; i < EMBED_DIM; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            sumsq_q  <= sumsq_d;
            mean_q   <= mean_d;
            bypass_q <= bypass_d;
            rad_q    <= rad_d;
            root_q   <= root_d;
            srem_q   <= srem_d;
            drem_q   <= drem_d;
            quot_q   <= quot_d;
            step_q   <= step_d;
            if (buf_we) begin
                buf_q[cnt_q] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_layer_norm_stream.sv
// tb_layer_norm_stream: directed and randomized tokens against a behavioural LayerNorm model.
// Checks reset values, latency, in_ready gating, output values/last flag, and stability under stalls.
// Drives inputs 1 time unit after each rising edge and observes there too.
`timescale 1ns/1ps
module tb_layer_norm_stream;

    localparam int DW = 16;
    localparam int N  = 8;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_ready;
    logic signed [DW-1:0] in_data;
    logic affine_bypass;
    logic signed [DW-1:0] gamma [N];
    logic signed [DW-1:0] beta  [N];
    logic out_valid;
    logic out_ready;
    logic signed [DW-1:0] out_data;
    logic out_last;
    logic busy;

    int total  = 0;
    int passed = 0;
    longint xv [N];
    longint ev [N];

    always #5 clk = ~clk;

    layer_norm_stream #(
        .DATA_WIDTH(16),
        .FRAC_BITS (8),
        .EMBED_DIM (8),
        .EPS       (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .affine_bypass(affine_bypass),
        .gamma_in     (gamma),
        .beta_in      (beta),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    // LayerNorm straight from the arithmetic definition
    function automatic void model(input logic byp);
        longint sum = 0;
        longint sq = 0;
        longint mean, vr, v, s, inv, n, y;
        for (int i = 0; i < N; i++) begin
            sum += xv[i];
            sq  += xv[i] * xv[i];
        end
        mean = floor_div(sum, N);
        vr   = sq / N - mean * mean;
        v    = ((vr < 0) ? 0 : vr) + 1;
        if (v > 64'sd4294967295) v = 64'sd4294967295;
        s = longint'($floor($sqrt(real'(v))));
        while (s * s > v) s--;
        while ((s + 1) * (s + 1) <= v) s++;
        if (s < 1) s = 1;
        inv = 65536 / s;
        for (int j = 0; j < N; j++) begin
            n = floor_div((xv[j] - mean) * inv, 256);
            if (byp) y = n;
            else     y = floor_div(n * longint'(gamma[j]), 256) + longint'(beta[j]);
            if (y > 32767)  y = 32767;
            if (y < -32768) y = -32768;
            ev[j] = y;
        end
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"},  out_last,  0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_busy"},      busy,      0);
    endtask

    task automatic send_token(input string tag, input logic byp, input bit gaps);
        for (int i = 0; i < N; i++) begin
            int guard = 0;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    tick();
                end
            end
            in_valid      = 1'b1;
            in_data       = DW'(xv[i]);
            affine_bypass = (i == 0) ? byp : logic'($urandom_range(0, 1));
            while (!in_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (guard >= 50) check({tag, "_in_ready_timeout"}, in_ready, 1);
            tick();
            if (i == 0) check({tag, "_busy_first"}, busy, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_first(input string tag);
        int n = 0;
        while (!out_valid && n < 100) begin
            in_valid = logic'($urandom_range(0, 1));
            in_data  = DW'($urandom);
            check({tag, "_in_ready_low"}, in_ready, 0);
            tick();
            n++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, n, 34);
    endtask

    task automatic collect(input string tag, input bit stall);
        for (int j = 0; j < N; j++) begin
            if (stall) begin
                int gap = $urandom_range(0, 3);
                out_ready = 1'b0;
                for (int k = 0; k < gap; k++) begin
                    check($sformatf("%s_hold_data%0d", tag, j), out_data, ev[j]);
                    check($sformatf("%s_hold_last%0d", tag, j), out_last, (j == N-1) ? 1 : 0);
                    check($sformatf("%s_hold_rdy%0d", tag, j), in_ready, 0);
                    tick();
                end
            end
            out_ready = 1'b1;
            check($sformatf("%s_valid%0d", tag, j), out_valid, 1);
            check($sformatf("%s_data%0d", tag, j), out_data, ev[j]);
            check($sformatf("%s_last%0d", tag, j), out_last, (j == N-1) ? 1 : 0);
            check($sformatf("%s_rdy%0d", tag, j), in_ready, 0);
            tick();
        end
        out_ready = 1'b0;
        check({tag, "_ready_back"}, in_ready, 1);
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    task automatic set_affine(input int g, input int b);
        for (int i = 0; i < N; i++) begin
            gamma[i] = DW'(g);
            beta[i]  = DW'(b);
        end
    endtask

    task automatic rand_token();
        int base = int'($urandom_range(0, 8000)) - 4000;
        int spread;
        int v;
        case ($urandom_range(0, 2))
            0:       spread = 3;
            1:       spread = 300;
            default: spread = 12000;
        endcase
        for (int i = 0; i < N; i++) begin
            v = base + int'($urandom_range(0, 2*spread)) - spread;
            if (v > 32767)  v = 32767;
            if (v < -32768) v = -32768;
            xv[i]    = v;
            gamma[i] = DW'(int'($urandom_range(0, 2048)) - 1024);
            beta[i]  = DW'(int'($urandom_range(0, 8000)) - 4000);
        end
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        affine_bypass = 1'b0;
        out_ready     = 1'b0;
        set_affine(0, 0);
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        // Alternating +/-256, unit gamma
        for (int i = 0; i < N; i++) xv[i] = (i % 2 == 0) ? 256 : -256;
        set_affine(256, 0);
        for (int j = 0; j < N; j++) ev[j] = (j % 2 == 0) ? 256 : -256;
        send_token("alt", 1'b0, 1'b0);
        wait_first("alt");
        collect("alt", 1'b0);

        // Same input, gamma 2.0, beta 0.5
        set_affine(512, 128);
        for (int j = 0; j < N; j++) ev[j] = (j % 2 == 0) ? 640 : -384;
        send_token("aff", 1'b0, 1'b0);
        wait_first("aff");
        collect("aff", 1'b0);

        // Constant input: variance is EPS alone, output equals beta
        for (int i = 0; i < N; i++) begin
            xv[i]    = 1000;
            gamma[i] = 16'sd256;
            beta[i]  = DW'(i * 10);
            ev[i]    = i * 10;
        end
        send_token("const", 1'b0, 1'b0);
        wait_first("const");
        collect("const", 1'b0);

        // One outlier: saturation on element 0
        xv[0] = 1792;
        for (int i = 1; i < N; i++) xv[i] = -256;
        set_affine(16384, 0);
        ev[0] = 32767;
        for (int j = 1; j < N; j++) ev[j] = -6144;
        send_token("sat", 1'b0, 1'b0);
        wait_first("sat");
        collect("sat", 1'b0);

        // Same token with affine bypass
        ev[0] = 672;
        for (int j = 1; j < N; j++) ev[j] = -96;
        send_token("byp", 1'b1, 1'b0);
        wait_first("byp");
        collect("byp", 1'b0);

        // Saturating token again under input gaps and output stalls
        ev[0] = 32767;
        for (int j = 1; j < N; j++) ev[j] = -6144;
        send_token("stall", 1'b0, 1'b1);
        wait_first("stall");
        collect("stall", 1'b1);

        // Reset after 5 of 8 inputs, then a clean token
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_reset("midrst");
        rst = 1'b0;
        for (int i = 0; i < N; i++) xv[i] = (i % 2 == 0) ? 256 : -256;
        set_affine(256, 0);
        for (int j = 0; j < N; j++) ev[j] = (j % 2 == 0) ? 256 : -256;
        send_token("post_rst", 1'b0, 1'b0);
        wait_first("post_rst");
        collect("post_rst", 1'b0);

        // Randomized tokens against the model
        for (int t = 0; t < 10; t++) begin
            logic byp;
            rand_token();
            byp = logic'($urandom_range(0, 1));
            model(byp);
            send_token($sformatf("rnd%0d", t), byp, 1'b1);
            wait_first($sformatf("rnd%0d", t));
            collect($sformatf("rnd%0d", t), (t % 3) != 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

endmodule
